instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 64: maximum instructions written per load session.
REQ-002 SHALL have i_clk  input  1: single clock, all state updates on rising edge.
REQ-003 SHALL have i_rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have i_start  input  1: begin or restart a session at i_base_addr.
REQ-005 SHALL have i_base_addr  input  32: first byte address of the session, word-aligned.
REQ-006 SHALL have i_valid  input  1: encode request valid.
REQ-007 SHALL have o_ready  output  1: loader can accept a request.
REQ-008 SHALL have i_type  input  3: 0 lw, 1 sw, 2 R-type, 3 beq, 4 I-type ALU, 5 jal, 6-7 illegal.
REQ-009 SHALL have i_rd, i_rs1, i_rs2  input  5 each: register fields.
REQ-010 SHALL have i_funct3  input  3 and i_funct7  input  7: function fields.
REQ-011 SHALL have i_imm  input  32: signed immediate, byte offset for beq and jal.
REQ-012 SHALL have i_last  input  1: request is the final instruction of the session.
REQ-013 SHALL have o_we  output  1, o_waddr  output  32, o_wdata  output  32: instruction-memory write port.
REQ-014 SHALL have o_count  output  16: words written in the current session.
REQ-015 SHALL have o_busy, o_done, o_err  output  1 each: session status.

Function
REQ-016 SHALL implement FSM states IDLE, ACCEPT, WRITE, DONE, ERR.
REQ-017 IDLE->ACCEPT on i_start, loading the address register with i_base_addr and clearing o_count and o_err.
REQ-018 SHALL drive o_ready=1 only in ACCEPT; a handshake is i_valid&&o_ready on a rising edge.
REQ-019 On handshake: encoded word, address and i_last registered; ACCEPT->WRITE.
REQ-020 In WRITE: o_we=1 for exactly one cycle with registered o_waddr/o_wdata; address+=4, o_count+=1 at that edge; next state DONE if stored i_last else ACCEPT. Throughput is 1 word per 2 cycles.
REQ-021 Encodings (opcode in [6:0]): lw {imm[11:0],rs1,funct3,rd,0000011}; I-ALU {imm[11:0],rs1,funct3,rd,0010011}; sw {imm[11:5],rs2,rs1,funct3,imm[4:0],0100011}; R {funct7,rs2,rs1,funct3,rd,0110011}; beq {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],1100011}; jal {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
REQ-022 Unused upper i_imm bits SHALL be ignored, with no range check.
REQ-023 Handshake with i_type 6/7, with beq/jal and i_imm[0]=1, or with o_count==MAX_WORDS SHALL go to ERR with no write and o_err=1.
REQ-024 ERR and DONE SHALL be sticky until i_start or reset; o_ready=0, o_we=0 in both.
REQ-025 o_busy=1 in ACCEPT and WRITE; o_done=1 only in DONE; o_err=1 only in ERR.
REQ-026 i_start in any state SHALL restart a session (state ACCEPT next cycle, address=i_base_addr, count=0); i_start in WRITE SHALL abort that write (o_we forced 0 that cycle).
REQ-027 Address increment SHALL wrap modulo 2^32.

Reset
REQ-028 Reset SHALL force IDLE with o_we=0, o_ready=0, o_busy=0, o_done=0, o_err=0, o_count=0, o_waddr=0, o_wdata=0, independent of the clock.
REQ-029 Reset asserted mid-session SHALL abandon it; after release the block stays in IDLE until i_start.

Verification
REQ-030 start base=0x100; lw rd=5 rs1=1 f3=2 imm=8, last=0 -> next cycle o_we=1, o_waddr=0x100, o_wdata=0x0080A283, o_count=1.
REQ-031 Continue: R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> o_waddr=0x104, o_wdata=0x002081B3; beq rs1=1 rs2=2 imm=8 -> 0x00208463 at 0x108.
REQ-032 jal rd=1 imm=16 last=1 -> 0x010000EF written, then o_done=1, o_ready=0, o_count=4.
REQ-033 i_type=6, or beq with imm=7 -> no o_we, o_err=1, held until i_start.
REQ-034 MAX_WORDS=2: third handshake -> ERR with o_count=2; i_rst_n low during WRITE -> o_we drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/instr_loader_if.sv
// Request, instruction-memory write and status signals of the instruction loader.
interface instr_loader_if;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_type;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [31:0] i_imm;
    logic        i_last;
    logic        o_we;
    logic [31:0] o_waddr;
    logic [31:0] o_wdata;
    logic [15:0] o_count;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_start, i_base_addr, i_valid, i_type, i_rd, i_rs1, i_rs2,
               i_funct3, i_funct7, i_imm, i_last,
        input  o_ready, o_we, o_waddr, o_wdata, o_count, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_base_addr, i_valid, i_type, i_rd, i_rs1, i_rs2,
               i_funct3, i_funct7, i_imm, i_last,
        output o_ready, o_we, o_waddr, o_wdata, o_count, o_busy, o_done, o_err
    );
endinterface

// File: rtl/instr_loader.sv
// Encodes RV32I instruction requests and writes them one per two cycles into
// instruction memory starting at a session base address.
module instr_loader #(
    parameter int MAX_WORDS = 64
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    instr_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERR} state_t;

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    state_t      r_state;
    logic [31:0] r_addr;
    logic        r_last;
    logic        r_we;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic [15:0] r_count;

    logic [31:0] w_word;
    logic        w_reject;
    logic        w_handshake;
    logic        w_unused;

    assign w_handshake = bus.i_valid && r_ready;
    assign w_unused    = ^bus.i_imm[31:21];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_word   = '0;
        w_reject = 1'b0;
        case (bus.i_type)
            3'd0: w_word = {bus.i_imm[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd, 7'b0000011};
            3'd1: w_word = {bus.i_imm[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                            bus.i_imm[4:0], 7'b0100011};
            3'd2: w_word = {bus.i_funct7, bus.i_rs2, bus.i_rs1, bus.i_funct3, bus.i_rd,
                            7'b0110011};
            3'd3: begin
                w_word   = {bus.i_imm[12], bus.i_imm[10:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                            bus.i_imm[4:1], bus.i_imm[11], 7'b1100011};
                w_reject = bus.i_imm[0];
            end
            3'd4: w_word = {bus.i_imm[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd, 7'b0010011};
            3'd5: begin
                w_word   = {bus.i_imm[20], bus.i_imm[10:1], bus.i_imm[11], bus.i_imm[19:12],
                            bus.i_rd, 7'b1101111};
                w_reject = bus.i_imm[0];
            end
            default: w_reject = 1'b1;
        endcase
        if (r_count == MAX_COUNT) w_reject = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_last  <= 1'b0;
            r_we    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_count <= '0;
        end else begin
            r_we <= 1'b0;
            if (bus.i_start) begin
                r_state <= ACCEPT;
                r_addr  <= bus.i_base_addr;
                r_count <= '0;
                r_ready <= 1'b1;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    ACCEPT: begin
                        if (w_handshake) begin
                            r_ready <= 1'b0;
                            if (w_reject) begin
                                r_state <= ERR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                // Address and count advance as the write is issued.
                                r_state <= WRITE;
                                r_we    <= 1'b1;
                                r_waddr <= r_addr;
                                r_wdata <= w_word;
                                r_last  <= bus.i_last;
                                r_addr  <= r_addr + 32'd4;
                                r_count <= r_count + 16'd1;
                            end
                        end
                    end
                    WRITE: begin
                        if (r_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ACCEPT;
                            r_ready <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A restart during WRITE must suppress the pending write in that same cycle.
    assign bus.o_we    = r_we && !bus.i_start;
    assign bus.o_ready = r_ready;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_err   = r_err;
    assign bus.o_waddr = r_waddr;
    assign bus.o_wdata = r_wdata;
    assign bus.o_count = r_count;
endmodule

// File: tb/tb_instr_loader.sv
// Randomized and directed checks of instr_loader against a transaction-level model.
module tb_instr_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_loader_if bus_a ();
    instr_loader_if bus_b ();

    instr_loader #(.MAX_WORDS(64)) u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
    instr_loader #(.MAX_WORDS(2))  u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

    logic        t_start = 1'b0;
    logic [31:0] t_base  = '0;
    logic        t_valid = 1'b0;
    logic [2:0]  t_type  = '0;
    logic [4:0]  t_rd = '0, t_rs1 = '0, t_rs2 = '0;
    logic [2:0]  t_f3 = '0;
    logic [6:0]  t_f7 = '0;
    logic [31:0] t_imm = '0;
    logic        t_last = 1'b0;

    assign bus_a.i_start = t_start;  assign bus_b.i_start = t_start;
    assign bus_a.i_base_addr = t_base; assign bus_b.i_base_addr = t_base;
    assign bus_a.i_valid = t_valid;  assign bus_b.i_valid = t_valid;
    assign bus_a.i_type = t_type;    assign bus_b.i_type = t_type;
    assign bus_a.i_rd = t_rd;        assign bus_b.i_rd = t_rd;
    assign bus_a.i_rs1 = t_rs1;      assign bus_b.i_rs1 = t_rs1;
    assign bus_a.i_rs2 = t_rs2;      assign bus_b.i_rs2 = t_rs2;
    assign bus_a.i_funct3 = t_f3;    assign bus_b.i_funct3 = t_f3;
    assign bus_a.i_funct7 = t_f7;    assign bus_b.i_funct7 = t_f7;
    assign bus_a.i_imm = t_imm;      assign bus_b.i_imm = t_imm;
    assign bus_a.i_last = t_last;    assign bus_b.i_last = t_last;

    // Observed outputs of whichever DUT is under test.
    logic        sel_b = 1'b0;
    logic        obs_we, obs_ready, obs_busy, obs_done, obs_err;
    logic [31:0] obs_waddr, obs_wdata;
    logic [15:0] obs_count;

    always_comb begin
        if (sel_b) begin
            obs_we = bus_b.o_we; obs_ready = bus_b.o_ready; obs_busy = bus_b.o_busy;
            obs_done = bus_b.o_done; obs_err = bus_b.o_err; obs_waddr = bus_b.o_waddr;
            obs_wdata = bus_b.o_wdata; obs_count = bus_b.o_count;
        end else begin
            obs_we = bus_a.o_we; obs_ready = bus_a.o_ready; obs_busy = bus_a.o_busy;
            obs_done = bus_a.o_done; obs_err = bus_a.o_err; obs_waddr = bus_a.o_waddr;
            obs_wdata = bus_a.o_wdata; obs_count = bus_a.o_count;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model: session address, words written and word limit of the DUT under test.
    logic [31:0] m_addr  = '0;
    int          m_count = 0;
    int          m_max   = 64;

    function automatic logic [31:0] bits(input logic [31:0] v, input int lo, input int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_encode(input logic [2:0] ty, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [31:0] imm);
        logic [31:0] base;
        base = (32'(rs1) << 15) | (32'(f3) << 12);
        case (ty)
            3'd0: return (bits(imm, 0, 12) << 20) | base | (32'(rd) << 7) | 32'h03;
            3'd4: return (bits(imm, 0, 12) << 20) | base | (32'(rd) << 7) | 32'h13;
            3'd1: return (bits(imm, 5, 7) << 25) | (32'(rs2) << 20) | base
                         | (bits(imm, 0, 5) << 7) | 32'h23;
            3'd2: return (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7) | 32'h33;
            3'd3: return (bits(imm, 12, 1) << 31) | (bits(imm, 5, 6) << 25) | (32'(rs2) << 20)
                         | base | (bits(imm, 1, 4) << 8) | (bits(imm, 11, 1) << 7) | 32'h63;
            default: return (bits(imm, 20, 1) << 31) | (bits(imm, 1, 10) << 21)
                            | (bits(imm, 11, 1) << 20) | (bits(imm, 12, 8) << 12)
                            | (32'(rd) << 7) | 32'h6F;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, obs_we, 0);
        check({tag, "_ready"}, obs_ready, 0);
        check({tag, "_busy"}, obs_busy, 0);
        check({tag, "_done"}, obs_done, 0);
        check({tag, "_err"}, obs_err, 0);
        check({tag, "_count"}, obs_count, 0);
        check({tag, "_waddr"}, obs_waddr, 0);
        check({tag, "_wdata"}, obs_wdata, 0);
    endtask

    task automatic do_start(input logic [31:0] base);
        t_start = 1'b1;
        t_base  = base;
        tick();
        t_start = 1'b0;
        m_addr  = base;
        m_count = 0;
        check("start_ready", obs_ready, 1);
        check("start_busy", obs_busy, 1);
        check("start_count", obs_count, 0);
        check("start_err", obs_err, 0);
        check("start_done", obs_done, 0);
    endtask

    task automatic send(input logic [2:0] ty, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last, output bit err);
        bit ok = 0;
        logic [31:0] exp_word;
        for (int i = 0; i < 4 && !ok; i++) begin
            if (obs_ready) ok = 1;
            else tick();
        end
        check("ready_wait", ok, 1);
        err = (ty >= 3'd6) || ((ty == 3'd3 || ty == 3'd5) && imm[0]) || (m_count == m_max);
        exp_word = ref_encode(ty, rd, rs1, rs2, f3, f7, imm);
        t_type = ty; t_rd = rd; t_rs1 = rs1; t_rs2 = rs2;
        t_f3 = f3; t_f7 = f7; t_imm = imm; t_last = last;
        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        if (err) begin
            check("err_we", obs_we, 0);
            check("err_flag", obs_err, 1);
            check("err_ready", obs_ready, 0);
            check("err_count", obs_count, 64'(m_count));
            repeat (3) @(posedge clk);
            #1;
            check("err_sticky", obs_err, 1);
            check("err_sticky_we", obs_we, 0);
        end else begin
            check("we", obs_we, 1);
            check("waddr", obs_waddr, m_addr);
            check("wdata", obs_wdata, exp_word);
            m_addr  = m_addr + 32'd4;
            m_count = m_count + 1;
            check("count", obs_count, 64'(m_count));
            check("write_busy", obs_busy, 1);
            tick();
            check("we_pulse", obs_we, 0);
            if (last) begin
                check("done", obs_done, 1);
                check("done_ready", obs_ready, 0);
                check("done_count", obs_count, 64'(m_count));
                tick();
                check("done_sticky", obs_done, 1);
            end else begin
                check("next_ready", obs_ready, 1);
            end
        end
    endtask

    task automatic rand_session();
        logic [31:0] base;
        logic [2:0]  ty;
        logic [31:0] imm;
        int          n;
        int          r;
        bit          err;
        if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFF0;
        else base = $urandom & ~32'h3;
        do_start(base);
        n = $urandom_range(1, 8);
        for (int k = 0; k < n; k++) begin
            r   = $urandom_range(0, 19);
            ty  = (r < 18) ? 3'(r % 6) : 3'(6 + (r & 1));
            imm = $urandom;
            if ((ty == 3'd3 || ty == 3'd5) && $urandom_range(0, 9) != 0) imm[0] = 1'b0;
            send(ty, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                 imm, k == n - 1, err);
            if (err) break;
        end
    endtask

    initial begin
        bit err;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_ready", obs_ready, 0);
        check("idle_busy", obs_busy, 0);

        // Directed program: lw, R, beq, jal.
        do_start(32'h100);
        send(3'd0, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 32'd8, 1'b0, err);
        check("lw_word", obs_wdata, 32'h0080_A283);
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, err);
        check("r_word", obs_wdata, 32'h0020_81B3);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0, err);
        check("beq_word", obs_wdata, 32'h0020_8463);
        check("beq_addr", obs_waddr, 32'h108);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1, err);
        check("jal_word", obs_wdata, 32'h0100_00EF);
        check("jal_count", obs_count, 4);

        // Illegal type and odd branch offset.
        do_start(32'h200);
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, err);
        do_start(32'h200);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0, err);

        // Restart during WRITE aborts the write.
        do_start(32'h300);
        t_type = 3'd0; t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        check("abort_pre_we", obs_we, 1);
        t_start = 1'b1;
        t_base  = 32'h400;
        #1;
        check("abort_we", obs_we, 0);
        tick();
        t_start = 1'b0;
        m_addr  = 32'h400;
        m_count = 0;
        check("abort_count", obs_count, 0);
        check("abort_ready", obs_ready, 1);
        send(3'd2, 5'd7, 5'd8, 5'd9, 3'd1, 7'h20, 32'd0, 1'b1, err);

        // Word limit on the MAX_WORDS=2 instance.
        sel_b = 1'b1;
        m_max = 2;
        do_start(32'h500);
        send(3'd4, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, err);
        send(3'd1, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFC, 1'b0, err);
        send(3'd0, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4, 1'b0, err);
        check("limit_err", err, 1);

        // Reset during WRITE.
        do_start(32'h600);
        t_type = 3'd2; t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        check("rst_pre_we", obs_we, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_reset_values("postrst");

        sel_b = 1'b0;
        m_max = 64;
        repeat (40) rand_session();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
